cc_depuncture: RTL and testbench
================================

CC_DEPUNCTURE -- requirements
Module: cc_depuncture

Interface
REQ-001 Parameter w, default 3: width of a two's-complement soft-decision symbol.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in_sym  input  w  received soft symbol, punctured CC stream order.
REQ-005 in_valid  input  1  in_sym valid this cycle.
REQ-006 in_sof  input  1  qualifies in_sym as the first symbol of a burst; meaningful only with in_valid.
REQ-007 in_ready  output  1  block accepts in_sym this cycle.
REQ-008 cc_rate  input  2  0=1/2, 1=2/3, 2=3/4, 3=5/6; sampled only on an accepted in_sof symbol.
REQ-009 out_x, out_y  output  w each  restored mother-code (rate 1/2) X/Y soft pair.
REQ-010 out_x_era, out_y_era  output  1 each  marks the corresponding symbol as an inserted erasure.
REQ-011 out_valid  output  1  pair valid; out_ready  input  1  downstream accepts the pair.

Function
REQ-012 Puncture masks (X;Y) per period SHALL be: 1/2 X=1 Y=1; 2/3 X=10 Y=11; 3/4 X=101 Y=110; 5/6 X=10101 Y=11010; transmit order per pair position is X then Y.
REQ-013 An input transfer SHALL occur when in_valid && in_ready; one symbol per cycle maximum.
REQ-014 Each transfer SHALL fill the next unmasked slot (X or Y) of the current pattern position; masked slots SHALL be filled with value 0 and the era flag set.
REQ-015 A pair SHALL be complete when its last unmasked slot is filled; it SHALL move to the output register the same edge, so out_valid rises one cycle after the completing transfer.
REQ-016 After a pair completes, the pattern position SHALL advance, wrapping from period-1 to 0 (periods 1, 2, 3, 5).
REQ-017 out_x/out_y/era flags SHALL be held stable while out_valid && !out_ready.
REQ-018 in_ready SHALL equal !(out_valid && !out_ready); a full output register accepted in the same cycle as a completing transfer SHALL not stall.
REQ-019 An accepted in_sof symbol SHALL latch cc_rate, reset position to 0, slot to X, discard any partially filled pair (no output), then be processed as the first symbol.
REQ-020 Symbols before the first in_sof after reset SHALL be consumed and discarded.
REQ-021 cc_rate changes without in_sof SHALL have no effect.
REQ-022 Throughput: rate 1/2 emits one pair per two accepted symbols; 3/4 emits three pairs per four symbols.

Reset
REQ-023 On reset low: out_valid=0, out_x=out_y=0, era flags=0, position=0, slot=X, latched rate=0, partial pair discarded, sof-seen flag cleared; in_ready=1.
REQ-024 Reset asserted mid-burst SHALL abort the burst; the pending output pair SHALL be lost.

Structure
REQ-025 Rate encodings, period lengths and X/Y mask constants SHALL live in the shared package fec_pkg, reused by the transmit-side CC puncturer.
REQ-026 One combinational sub-module, cc_punct_table (rate, position -> x_keep, y_keep, last_pos), SHALL hold the masks; the remainder is the fill counter, staging register and output register.

Verification
REQ-027 Rate 1/2, sof + symbols 1,2,3,4, out_ready=1 -> pairs (1,2),(3,4), no era flags, out_valid one cycle after symbols 2 and 4.
REQ-028 Rate 3/4, sof + 1..8 -> pairs (1,2),(0e,3),(4,0e),(5,6),(0e,7),(8,0e); e = era flag set.
REQ-029 Rate 5/6, sof + 1..6 -> (1,2),(0e,3),(4,0e),(0e,5),(6,0e).
REQ-030 Rate 2/3, out_ready held 0 for 5 cycles after first pair -> pair stable, in_ready=0 after staging fills, no symbol lost; release -> sequence continues (0e,3).
REQ-031 Rate 3/4, sof mid-pattern after 3 symbols with cc_rate=0 -> partial pair dropped, following pairs use rate 1/2 from position 0.
REQ-032 Reset low mid-burst for 1 cycle -> out_valid=0 immediately; symbols without sof afterwards discarded.

Source files
------------

// File: rtl/fec_pkg.sv
// Shared FEC definitions for the convolutional-code puncturer/depuncturer pair.
// Holds the code-rate encodings, period lengths and per-position X/Y keep masks
// (bit index = pattern position, position 0 transmitted first).
package fec_pkg;

  localparam int unsigned POS_W  = 3;
  localparam int unsigned MASK_W = 1 << POS_W;

  typedef enum logic [1:0] {
    RATE_1_2 = 2'd0,
    RATE_2_3 = 2'd1,
    RATE_3_4 = 2'd2,
    RATE_5_6 = 2'd3
  } cc_rate_e;

  // Next slot to fill within the current pair
  typedef enum logic {
    SLOT_X = 1'b0,
    SLOT_Y = 1'b1
  } slot_e;

  // Puncture period lengths in pairs
  localparam logic [POS_W-1:0] PERIOD_1_2 = 3'd1;
  localparam logic [POS_W-1:0] PERIOD_2_3 = 3'd2;
  localparam logic [POS_W-1:0] PERIOD_3_4 = 3'd3;
  localparam logic [POS_W-1:0] PERIOD_5_6 = 3'd5;

  // Keep masks: 1 = symbol transmitted, 0 = punctured
  localparam logic [MASK_W-1:0] X_MASK_1_2 = 8'b0000_0001;
  localparam logic [MASK_W-1:0] Y_MASK_1_2 = 8'b0000_0001;
  localparam logic [MASK_W-1:0] X_MASK_2_3 = 8'b0000_0001;
  localparam logic [MASK_W-1:0] Y_MASK_2_3 = 8'b0000_0011;
  localparam logic [MASK_W-1:0] X_MASK_3_4 = 8'b0000_0101;
  localparam logic [MASK_W-1:0] Y_MASK_3_4 = 8'b0000_0011;
  localparam logic [MASK_W-1:0] X_MASK_5_6 = 8'b0001_0101;
  localparam logic [MASK_W-1:0] Y_MASK_5_6 = 8'b0000_1011;

  function automatic logic [POS_W-1:0] period_len(input cc_rate_e rate);
    logic [POS_W-1:0] len;
    case (rate)
      RATE_1_2: len = PERIOD_1_2;
      RATE_2_3: len = PERIOD_2_3;
      RATE_3_4: len = PERIOD_3_4;
      default:  len = PERIOD_5_6;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/cc_depuncture_if.sv
// Stream interface for the depuncturer.
//   in_*   : punctured soft-symbol stream (valid/ready), in_sof marks burst start,
//            cc_rate qualifies the burst's code rate (2 bits, see fec_pkg).
//   out_*  : restored rate-1/2 X/Y soft pair with erasure flags (valid/ready).
// slave  = depuncturer view, master = upstream/downstream environment view.
interface cc_depuncture_if #(
  parameter int unsigned w = 3
);
  logic [w-1:0] in_sym;
  logic         in_valid;
  logic         in_sof;
  logic         in_ready;
  logic [1:0]   cc_rate;
  logic [w-1:0] out_x;
  logic [w-1:0] out_y;
  logic         out_x_era;
  logic         out_y_era;
  logic         out_valid;
  logic         out_ready;

  modport slave (
    input  in_sym, in_valid, in_sof, cc_rate, out_ready,
    output in_ready, out_x, out_y, out_x_era, out_y_era, out_valid
  );

  modport master (
    output in_sym, in_valid, in_sof, cc_rate, out_ready,
    input  in_ready, out_x, out_y, out_x_era, out_y_era, out_valid
  );
endinterface

// File: rtl/cc_punct_table.sv
// Combinational puncture-pattern lookup.
//   rate     : code rate
//   pos      : pair position within the puncture period
//   x_keep   : X symbol transmitted at this position
//   y_keep   : Y symbol transmitted at this position
//   last_pos : position is the final one of the period
module cc_punct_table
  import fec_pkg::*;
(
  input  cc_rate_e         rate,
  input  logic [POS_W-1:0] pos,
  output logic             x_keep,
  output logic             y_keep,
  output logic             last_pos
);

  logic [MASK_W-1:0] x_mask;
  logic [MASK_W-1:0] y_mask;

  // Mask selection by rate
  always_comb begin
    x_mask = X_MASK_1_2;
    y_mask = Y_MASK_1_2;
    case (rate)
      RATE_1_2: begin x_mask = X_MASK_1_2; y_mask = Y_MASK_1_2; end
      RATE_2_3: begin x_mask = X_MASK_2_3; y_mask = Y_MASK_2_3; end
      RATE_3_4: begin x_mask = X_MASK_3_4; y_mask = Y_MASK_3_4; end
      default:  begin x_mask = X_MASK_5_6; y_mask = Y_MASK_5_6; end
    endcase
  end

  assign x_keep   = x_mask[pos];
  assign y_keep   = y_mask[pos];
  assign last_pos = (pos == (period_len(rate) - POS_W'(1)));

endmodule

// File: rtl/cc_depuncture.sv
// Convolutional-code depuncturer: rebuilds rate-1/2 X/Y soft pairs from a
// punctured symbol stream, inserting zero-valued erasures in punctured slots.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : cc_depuncture_if.slave (input stream, output pair stream)
// A held X symbol waits in a staging register until its Y arrives; a completed
// pair is written to the output register on the completing edge.
module cc_depuncture
  import fec_pkg::*;
#(
  parameter int unsigned w = 3
) (
  input logic            clk,
  input logic            reset,
  cc_depuncture_if.slave bus
);

  cc_rate_e         rate_q, rate_d;
  logic [POS_W-1:0] pos_q, pos_d;
  slot_e            slot_q, slot_d;
  logic             sof_seen_q, sof_seen_d;
  logic [w-1:0]     stage_x_q, stage_x_d;
  logic             out_valid_q, out_valid_d;
  logic [w-1:0]     out_x_q, out_x_d;
  logic [w-1:0]     out_y_q, out_y_d;
  logic             out_x_era_q, out_x_era_d;
  logic             out_y_era_q, out_y_era_d;

  logic             accept;
  cc_rate_e         eff_rate;
  logic [POS_W-1:0] eff_pos;
  slot_e            eff_slot;
  logic             x_keep;
  logic             y_keep;
  logic             last_pos;

  // Stall only when the output register is full and not being drained
  assign bus.in_ready = !(out_valid_q && !bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // A start-of-burst symbol is decoded with its own rate from position 0, slot X
  assign eff_rate = bus.in_sof ? cc_rate_e'(bus.cc_rate) : rate_q;
  assign eff_pos  = bus.in_sof ? '0 : pos_q;
  assign eff_slot = bus.in_sof ? SLOT_X : slot_q;

  cc_punct_table u_table (
    .rate     (eff_rate),
    .pos      (eff_pos),
    .x_keep   (x_keep),
    .y_keep   (y_keep),
    .last_pos (last_pos)
  );

  // Next-state: fill counter, staging and output register
  always_comb begin
    rate_d      = rate_q;
    pos_d       = pos_q;
    slot_d      = slot_q;
    sof_seen_d  = sof_seen_q;
    stage_x_d   = stage_x_q;
    out_valid_d = out_valid_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_x_era_d = out_x_era_q;
    out_y_era_d = out_y_era_q;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (bus.in_sof) begin
        rate_d     = cc_rate_e'(bus.cc_rate);
        sof_seen_d = 1'b1;
      end
      // Pre-sof symbols fall through and are dropped
      if (bus.in_sof || sof_seen_q) begin
        if (eff_slot == SLOT_X && x_keep && y_keep) begin
          stage_x_d = bus.in_sym;
          slot_d    = SLOT_Y;
          pos_d     = eff_pos;
        end else begin
          out_valid_d = 1'b1;
          if (eff_slot == SLOT_Y) begin
            out_x_d     = stage_x_q;
            out_x_era_d = 1'b0;
            out_y_d     = bus.in_sym;
            out_y_era_d = 1'b0;
          end else if (x_keep) begin
            out_x_d     = bus.in_sym;
            out_x_era_d = 1'b0;
            out_y_d     = '0;
            out_y_era_d = 1'b1;
          end else begin
            out_x_d     = '0;
            out_x_era_d = 1'b1;
            out_y_d     = bus.in_sym;
            out_y_era_d = 1'b0;
          end
          slot_d = SLOT_X;
          pos_d  = last_pos ? '0 : eff_pos + POS_W'(1);
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rate_q      <= RATE_1_2;
      pos_q       <= '0;
      slot_q      <= SLOT_X;
      sof_seen_q  <= 1'b0;
      stage_x_q   <= '0;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_x_era_q <= 1'b0;
      out_y_era_q <= 1'b0;
    end else begin
      rate_q      <= rate_d;
      pos_q       <= pos_d;
      slot_q      <= slot_d;
      sof_seen_q  <= sof_seen_d;
      stage_x_q   <= stage_x_d;
      out_valid_q <= out_valid_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_x_era_q <= out_x_era_d;
      out_y_era_q <= out_y_era_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_x     = out_x_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_x_era = out_x_era_q;
  assign bus.out_y_era = out_y_era_q;

endmodule

// File: tb/tb_cc_depuncture.sv
// Directed bench for cc_depuncture: hand-computed expected pair lists per burst.
module tb_cc_depuncture;

  localparam int unsigned W = 5;

  // Pair encoding: {x_era, x, y_era, y}
  typedef logic [2*W+1:0] pair_t;

  logic clk = 1'b0;
  logic reset;

  cc_depuncture_if #(.w(W)) bus ();

  cc_depuncture #(.w(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  pair_t got_q[$];
  pair_t exp_q[$];

  function automatic pair_t mk(input int x, input bit xe, input int y, input bit ye);
    return {xe, W'(x), ye, W'(y)};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output capture: a pair is transferred when valid && ready
  always @(negedge clk) begin
    if (reset && bus.out_valid && bus.out_ready)
      got_q.push_back({bus.out_x_era, bus.out_x, bus.out_y_era, bus.out_y});
  end

  task automatic send_sym(input int sym, input bit sof);
    int waited = 0;
    bus.in_sym   = W'(sym);
    bus.in_sof   = sof;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.in_ready) check_eq("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_sof = 1'b0;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic check_phase(input string tag);
    repeat (4) @(negedge clk);
    check_eq({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_eq($sformatf("%s_pair%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.in_sym    = '0;
    bus.cc_rate   = 2'd0;
    bus.out_ready = 1'b1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_x", 32'(bus.out_x), 32'd0);
    check_eq("rst_out_y", 32'(bus.out_y), 32'd0);
    check_eq("rst_eras", 32'({bus.out_x_era, bus.out_y_era}), 32'd0);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Symbols before any sof are dropped
    send_sym(7, 1'b0);
    send_sym(7, 1'b0);
    idle();
    check_phase("presof");

    // Rate 1/2; cc_rate change without sof must be ignored
    bus.cc_rate = 2'd0;
    send_sym(1, 1'b1);
    check_eq("r12_ov_s1", 32'(bus.out_valid), 32'd0);
    send_sym(2, 1'b0);
    check_eq("r12_ov_s2", 32'(bus.out_valid), 32'd1);
    bus.cc_rate = 2'd3;
    send_sym(3, 1'b0);
    check_eq("r12_ov_s3", 32'(bus.out_valid), 32'd0);
    send_sym(4, 1'b0);
    check_eq("r12_ov_s4", 32'(bus.out_valid), 32'd1);
    idle();
    exp_q.push_back(mk(1, 0, 2, 0));
    exp_q.push_back(mk(3, 0, 4, 0));
    check_phase("r12");

    // Rate 3/4
    bus.cc_rate = 2'd2;
    send_sym(1, 1'b1);
    for (int i = 2; i <= 8; i++) send_sym(i, 1'b0);
    idle();
    exp_q.push_back(mk(1, 0, 2, 0));
    exp_q.push_back(mk(0, 1, 3, 0));
    exp_q.push_back(mk(4, 0, 0, 1));
    exp_q.push_back(mk(5, 0, 6, 0));
    exp_q.push_back(mk(0, 1, 7, 0));
    exp_q.push_back(mk(8, 0, 0, 1));
    check_phase("r34");

    // Rate 5/6
    bus.cc_rate = 2'd3;
    send_sym(1, 1'b1);
    for (int i = 2; i <= 6; i++) send_sym(i, 1'b0);
    idle();
    exp_q.push_back(mk(1, 0, 2, 0));
    exp_q.push_back(mk(0, 1, 3, 0));
    exp_q.push_back(mk(4, 0, 0, 1));
    exp_q.push_back(mk(0, 1, 5, 0));
    exp_q.push_back(mk(6, 0, 0, 1));
    check_phase("r56");

    // Rate 2/3 with downstream backpressure after the first pair
    bus.cc_rate = 2'd1;
    send_sym(1, 1'b1);
    send_sym(2, 1'b0);
    bus.out_ready = 1'b0;
    bus.in_sym    = W'(3);
    bus.in_valid  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_eq("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check_eq("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check_eq("bp_pair_hold", 32'(pair_t'({bus.out_x_era, bus.out_x, bus.out_y_era, bus.out_y})),
               32'(mk(1, 0, 2, 0)));
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send_sym(3, 1'b0);
    check_eq("bp_no_stall", 32'(bus.out_valid), 32'd1);
    send_sym(4, 1'b0);
    send_sym(5, 1'b0);
    idle();
    exp_q.push_back(mk(1, 0, 2, 0));
    exp_q.push_back(mk(0, 1, 3, 0));
    exp_q.push_back(mk(4, 0, 5, 0));
    check_phase("r23_bp");

    // Rate 3/4 burst restarted by sof at rate 1/2 after three symbols
    bus.cc_rate = 2'd2;
    send_sym(1, 1'b1);
    send_sym(2, 1'b0);
    send_sym(3, 1'b0);
    bus.cc_rate = 2'd0;
    send_sym(10, 1'b1);
    send_sym(11, 1'b0);
    send_sym(12, 1'b0);
    send_sym(13, 1'b0);
    idle();
    exp_q.push_back(mk(1, 0, 2, 0));
    exp_q.push_back(mk(0, 1, 3, 0));
    exp_q.push_back(mk(10, 0, 11, 0));
    exp_q.push_back(mk(12, 0, 13, 0));
    check_phase("sof_mid");

    // Sof with a half-filled pair pending drops the held X
    bus.cc_rate = 2'd0;
    send_sym(20, 1'b1);
    send_sym(21, 1'b1);
    send_sym(22, 1'b0);
    idle();
    exp_q.push_back(mk(21, 0, 22, 0));
    check_phase("sof_drop");

    // Reset mid-burst with a pending output pair
    bus.cc_rate = 2'd0;
    send_sym(1, 1'b1);
    send_sym(2, 1'b0);
    bus.out_ready = 1'b0;
    idle();
    @(negedge clk);
    check_eq("prerst_out_valid", 32'(bus.out_valid), 32'd1);
    reset = 1'b0;
    #1;
    check_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 5; i <= 8; i++) send_sym(i, 1'b0);
    idle();
    check_phase("post_rst_nosof");
    send_sym(9, 1'b1);
    send_sym(10, 1'b0);
    idle();
    exp_q.push_back(mk(9, 0, 10, 0));
    check_phase("post_rst_sof");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
